decode_stage: RTL

//  Parametrised, pipelined successor to the single-cycle instruction decoder.

---
 rtl/decode_stage.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Pipelined instruction decoder. It sits between fetch and register read.
// Raw instruction words arrive over a valid/ready handshake. Each word is split
// into these fields:
//   - opcode class
//   - rd/rn/rm register indices
//   - read/write enables
//   - one sign-extended immediate
// The result is held in a single registered output stage. A one-word skid
// register behind it lets the stage keep in_ready high for a full cycle under
// backpressure, so the stage holds at most two words.
//
// Optional feature (compile-time macro DECODE_HAZARD_EN):
//   When defined, the rd/rd_we of every issued word is remembered. raw_hazard
//   flags a read-after-write dependency of the word currently presented on that
//   previously issued word. When undefined, raw_hazard is tied low and no
//   history state exists.
//
// Ports:
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous active-high reset (overrides flush)
//   flush      in   synchronous flush: drops same-cycle input and all held words
//   in_valid   in   instruction word valid
//   in_ready   out  stage can accept (= ~skid_full & ~rst)
//   inst       in   instruction word [INST_W-1:0]
//   out_valid  out  decoded word valid
//   out_ready  in   downstream accepts decoded word
//   opcode     out  class field [OPC_W-1:0]
//   rd/rn/rm   out  raw register index fields [REG_AW-1:0]
//   rd_we      out  rd is written
//   rn_en      out  rn is read
//   rm_en      out  rm is read
//   imm        out  sign-extended immediate [IMM_OUT_W-1:0], 0 for class R
//   raw_hazard out  RAW dependency on the previously issued word
// -----------------------------------------------------------------------------
module decode_stage #(
   parameter int INST_W    = 26,
   parameter int OPC_W     = 2,
   parameter int REG_AW    = 5,
   parameter int IMM_OUT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INST_W-1:0]    inst,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OPC_W-1:0]     opcode,
   output logic [REG_AW-1:0]    rd,
   output logic [REG_AW-1:0]    rn,
   output logic [REG_AW-1:0]    rm,
   output logic                 rd_we,
   output logic                 rn_en,
   output logic                 rm_en,
   output logic [IMM_OUT_W-1:0] imm,
   output logic                 raw_hazard
);

   typedef struct packed {
      logic [OPC_W-1:0]     opc;
      logic [REG_AW-1:0]    rd;
      logic [REG_AW-1:0]    rn;
      logic [REG_AW-1:0]    rm;
      logic                 rd_we;
      logic                 rn_en;
      logic                 rm_en;
      logic [IMM_OUT_W-1:0] imm;
   } dec_t;

   // Pure field extraction. Register indices are always passed through raw;
   // only the enables and the immediate depend on the class.
   function automatic dec_t decode(input logic [INST_W-1:0] w);
      dec_t                        d;
      logic signed [2*REG_AW-1:0]  imm10;
      logic signed [3*REG_AW-1:0]  imm15;
      logic signed [4*REG_AW-1:0]  imm20;
      d     = '0;
      imm10 = w[4*REG_AW-1:2*REG_AW];
      imm15 = w[4*REG_AW-1:REG_AW];
      imm20 = w[4*REG_AW-1:0];
      d.opc = w[INST_W-1 -: OPC_W];
      d.rd  = w[REG_AW-1:0];
      d.rn  = w[2*REG_AW-1:REG_AW];
      d.rm  = w[3*REG_AW-1:2*REG_AW];
      // Classes are selected by the low two bits of the opcode field.
      case (d.opc[1:0])
         2'b00: begin
            d.rd_we = 1'b1;
            d.rn_en = 1'b1;
            d.rm_en = 1'b1;
         end
         2'b01: begin
            d.rd_we = 1'b1;
            d.rn_en = 1'b1;
            d.imm   = IMM_OUT_W'(imm10);
         end
         2'b10: begin
            d.rd_we = 1'b1;
            d.imm   = IMM_OUT_W'(imm15);
         end
         default: begin
            d.imm   = IMM_OUT_W'(imm20);
         end
      endcase
      return d;
   endfunction

   dec_t              out_q, out_d;
   logic              out_valid_q, out_valid_d;
   logic [INST_W-1:0] skid_q, skid_d;
   logic              skid_full_q, skid_full_d;

   logic accept;
   logic issue;
   logic load_out;

   assign in_ready = ~skid_full_q & ~rst;
   assign accept   = in_valid & in_ready;
   assign issue    = out_valid_q & out_ready;
   // The output register may take a new word whenever it is empty or its
   // current word leaves this cycle.
   assign load_out = ~out_valid_q | out_ready;

`ifdef DECODE_HAZARD_EN
   logic [REG_AW-1:0] prev_rd_q, prev_rd_d;
   logic              prev_we_q, prev_we_d;
`endif

   always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      skid_d      = skid_q;
      skid_full_d = skid_full_q;
`ifdef DECODE_HAZARD_EN
      prev_rd_d   = prev_rd_q;
      prev_we_d   = prev_we_q;
`endif
      if (flush) begin
         out_d       = '0;
         out_valid_d = 1'b0;
         skid_full_d = 1'b0;
`ifdef DECODE_HAZARD_EN
         prev_rd_d   = '0;
         prev_we_d   = 1'b0;
`endif
      end else begin
`ifdef DECODE_HAZARD_EN
         if (issue) begin
            prev_rd_d = out_q.rd;
            prev_we_d = out_q.rd_we;
         end
`endif
         if (load_out) begin
            // The skid word is older than anything on the input, so it goes
            // first. in_ready is low while the skid is full, so no input word
            // can be lost in that case.
            if (skid_full_q) begin
               out_d       = decode(skid_q);
               out_valid_d = 1'b1;
               skid_full_d = 1'b0;
            end else if (accept) begin
               out_d       = decode(inst);
               out_valid_d = 1'b1;
            end else begin
               out_valid_d = 1'b0;
            end
         end else if (accept) begin
            // The output is stalled, so park the accepted word in the skid.
            skid_d      = inst;
            skid_full_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         skid_q      <= '0;
         skid_full_q <= 1'b0;
`ifdef DECODE_HAZARD_EN
         prev_rd_q   <= '0;
         prev_we_q   <= 1'b0;
`endif
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         skid_q      <= skid_d;
         skid_full_q <= skid_full_d;
`ifdef DECODE_HAZARD_EN
         prev_rd_q   <= prev_rd_d;
         prev_we_q   <= prev_we_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign opcode    = out_q.opc;
   assign rd        = out_q.rd;
   assign rn        = out_q.rn;
   assign rm        = out_q.rm;
   assign rd_we     = out_q.rd_we;
   assign rn_en     = out_q.rn_en;
   assign rm_en     = out_q.rm_en;
   assign imm       = out_q.imm;

`ifdef DECODE_HAZARD_EN
   // Register 0 is never a real destination, so it never hazards.
   assign raw_hazard = out_valid_q & prev_we_q & (prev_rd_q != '0) &
                       ((out_q.rn_en & (out_q.rn == prev_rd_q)) |
                        (out_q.rm_en & (out_q.rm == prev_rd_q)));
`else
   assign raw_hazard = 1'b0;
`endif

endmodule
